// File: rtl/eth_wrr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : eth_wrr_arbiter
//  Purpose  : Weighted round-robin arbiter for Ethernet frame requesters.
//             A granted port keeps the grant for up to weight[i] frames
//             (one "turn"). The grant only changes when the granted port
//             acknowledges the last beat of a frame. Arbitration is blocking:
//             dropping a request does not release the grant until the
//             in-flight frame is acknowledged.
//  Ports    : clk            - rising-edge clock
//             rst_n          - asynchronous active-low reset
//             request        - per-port "frame header pending" level
//             acknowledge    - per-port last-beat-accepted pulse
//             weight         - per-port frames-per-turn, WEIGHT_WIDTH each
//             grant          - one-hot registered grant
//             grant_valid    - grant is non-zero
//             grant_encoded  - binary index of the (last) granted port
//             credit         - frames left in this turn, incl. in-flight one
//  Revision : 1.0 - initial release
// ============================================================================
module eth_wrr_arbiter #(
    parameter int PORTS        = 4,
    parameter int WEIGHT_WIDTH = 4,
    parameter int CL_PORTS     = $clog2(PORTS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [PORTS-1:0]              request,
    input  logic [PORTS-1:0]              acknowledge,
    input  logic [PORTS*WEIGHT_WIDTH-1:0] weight,
    output logic [PORTS-1:0]              grant,
    output logic                          grant_valid,
    output logic [CL_PORTS-1:0]           grant_encoded,
    output logic [WEIGHT_WIDTH-1:0]       credit
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                   state_q,  state_d;
    logic [PORTS-1:0]         grant_q,  grant_d;
    logic                     valid_q;
    logic [CL_PORTS-1:0]      enc_q,    enc_d;
    logic [CL_PORTS-1:0]      rr_ptr_q, rr_ptr_d;
    logic [WEIGHT_WIDTH-1:0]  credit_q, credit_d;

    logic [WEIGHT_WIDTH-1:0]  port_weight [PORTS];
    logic [PORTS-1:0]         eligible;

    // A zero weight disables the port entirely.
    generate
        for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
            assign port_weight[gi] = weight[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            assign eligible[gi]    = request[gi] & (|port_weight[gi]);
        end
    endgenerate

    // Round-robin search starting at rr_ptr+1 and wrapping. The pointer
    // always holds the last granted port, so that port is visited last:
    // it is only re-picked when no other port is eligible. Iterating from
    // the farthest offset down lets the nearest eligible port win.
    logic                pick_found;
    logic [CL_PORTS-1:0] pick_idx;
    int                  cand_sum;
    logic [CL_PORTS-1:0] cand_idx;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr_q;
        cand_sum   = 0;
        cand_idx   = '0;
        for (int k = PORTS; k >= 1; k--) begin
            cand_sum = int'(rr_ptr_q) + k;
            if (cand_sum >= PORTS) begin
                cand_sum = cand_sum - PORTS;
            end
            cand_idx = CL_PORTS'(cand_sum);
            if (eligible[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Next-state logic
    logic do_load;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        enc_d    = enc_q;
        rr_ptr_d = rr_ptr_q;
        credit_d = credit_q;
        do_load  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    do_load = 1'b1;
                end
            end
            ST_HOLD: begin
                // Only the granted port's acknowledge matters.
                if (acknowledge[enc_q]) begin
                    if ((credit_q > WEIGHT_WIDTH'(1)) && request[enc_q]) begin
                        credit_d = credit_q - WEIGHT_WIDTH'(1);
                    end else if (pick_found) begin
                        do_load = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        grant_d  = '0;
                        credit_d = '0;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                grant_d  = '0;
                credit_d = '0;
            end
        endcase

        // Start a new turn: weight is sampled only here.
        if (do_load) begin
            state_d  = ST_HOLD;
            grant_d  = {{(PORTS-1){1'b0}}, 1'b1} << pick_idx;
            enc_d    = pick_idx;
            rr_ptr_d = pick_idx;
            credit_d = port_weight[pick_idx];
        end
    end

    // Pointer resets to the last port so that port 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            valid_q  <= 1'b0;
            enc_q    <= '0;
            rr_ptr_q <= CL_PORTS'(PORTS - 1);
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            valid_q  <= |grant_d;
            enc_q    <= enc_d;
            rr_ptr_q <= rr_ptr_d;
            credit_q <= credit_d;
        end
    end

    assign grant         = grant_q;
    assign grant_valid   = valid_q;
    assign grant_encoded = enc_q;
    assign credit        = credit_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_wrr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_eth_wrr_arbiter
//  Purpose  : Self-checking bench for eth_wrr_arbiter. Directed scenarios
//             with fixed expected values, followed by randomized traffic
//             compared against a frame-level behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_eth_wrr_arbiter;

    localparam int P  = 4;
    localparam int WW = 4;
    localparam int CL = 2;

    logic              clk;
    logic              rst_n;
    logic [P-1:0]      request;
    logic [P-1:0]      acknowledge;
    logic [P*WW-1:0]   weight;
    logic [P-1:0]      grant;
    logic              grant_valid;
    logic [CL-1:0]     grant_encoded;
    logic [WW-1:0]     credit;

    eth_wrr_arbiter #(
        .PORTS        (P),
        .WEIGHT_WIDTH (WW),
        .CL_PORTS     (CL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .request       (request),
        .acknowledge   (acknowledge),
        .weight        (weight),
        .grant         (grant),
        .grant_valid   (grant_valid),
        .grant_encoded (grant_encoded),
        .credit        (credit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: who holds the turn (-1 = nobody), frames left,
    // last granted port, last reported index.
    int m_owner;
    int m_credit;
    int m_last;
    int m_enc;

    function automatic int wt(input int i);
        return int'(weight[i*WW +: WW]);
    endfunction

    // Nearest requesting, enabled port after 'from', visiting 'from' last.
    function automatic int next_port(input int from);
        for (int k = 1; k <= P; k++) begin
            int j;
            j = (from + k) % P;
            if (request[j] && wt(j) != 0) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_credit = 0;
        m_last   = P - 1;
        m_enc    = 0;
    endtask

    task automatic start_turn(input int p);
        m_owner  = p;
        m_credit = wt(p);
        m_last   = p;
        m_enc    = p;
    endtask

    // One clock edge worth of frame-level behaviour.
    task automatic model_edge();
        int n;
        if (m_owner < 0) begin
            n = next_port(m_last);
            if (n >= 0) start_turn(n);
        end else if (acknowledge[m_owner]) begin
            if (m_credit > 1 && request[m_owner]) begin
                m_credit = m_credit - 1;
            end else begin
                n = next_port(m_last);
                if (n >= 0) start_turn(n);
                else begin
                    m_owner  = -1;
                    m_credit = 0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [31:0] exp_grant;
        exp_grant = (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
        chk({tag, "_grant"},  {28'd0, grant},        exp_grant);
        chk({tag, "_valid"},  {31'd0, grant_valid},  (m_owner < 0) ? 32'd0 : 32'd1);
        chk({tag, "_enc"},    {30'd0, grant_encoded}, m_enc);
        chk({tag, "_credit"}, {28'd0, credit},       m_credit);
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic pulse_ack(input logic [P-1:0] mask, input string tag);
        acknowledge = mask;
        step(tag);
        acknowledge = '0;
    endtask

    int seq_port [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
    int seq_cred [8] = '{3, 2, 1, 1, 3, 2, 1, 1};

    initial begin
        rst_n       = 1'b0;
        request     = '0;
        acknowledge = '0;
        weight      = {4'd1, 4'd1, 4'd1, 4'd1};
        model_reset();

        // Reset state
        #12;
        chk("rst_grant",  {28'd0, grant},         32'd0);
        chk("rst_valid",  {31'd0, grant_valid},   32'd0);
        chk("rst_enc",    {30'd0, grant_encoded}, 32'd0);
        chk("rst_credit", {28'd0, credit},        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("idle");
        chk("idle_grant", {28'd0, grant}, 32'd0);

        // Basic alternation with unit weights
        request = 4'b0101;
        step("b0");
        chk("b_first",  {28'd0, grant}, 32'b0001);
        pulse_ack(4'b0001, "b1");
        chk("b_second", {28'd0, grant}, 32'b0100);
        pulse_ack(4'b0100, "b2");
        chk("b_third",  {28'd0, grant}, 32'b0001);
        request = '0;
        pulse_ack(4'b0001, "b3");
        chk("b_idle",   {31'd0, grant_valid}, 32'd0);

        // Weighted turn: port 1 weight 3
        weight  = {4'd1, 4'd1, 4'd3, 4'd1};
        request = 4'b0011;
        step("w0");
        for (int f = 0; f < 8; f++) begin
            chk($sformatf("w_grant%0d", f),  {28'd0, grant},  32'd1 << seq_port[f]);
            chk($sformatf("w_credit%0d", f), {28'd0, credit}, seq_cred[f]);
            pulse_ack(P'(1) << seq_port[f], "w");
        end
        request = '0;
        pulse_ack(4'b0010, "w_end");
        chk("w_idle", {31'd0, grant_valid}, 32'd0);

        // Disabled port never granted, enabling it grants next cycle
        weight  = {4'd1, 4'd0, 4'd1, 4'd1};
        request = 4'b0100;
        for (int c = 0; c < 100; c++) begin
            step("z");
            chk("z_valid", {31'd0, grant_valid}, 32'd0);
        end
        weight = {4'd1, 4'd2, 4'd1, 4'd1};
        step("z_en");
        chk("z_grant",  {28'd0, grant},  32'b0100);
        chk("z_credit", {28'd0, credit}, 32'd2);

        // Request dropped with credit left: turn ends on ack, no bubble
        request = 4'b0001;
        pulse_ack(4'b0100, "n0");
        chk("n_grant",  {28'd0, grant},  32'b0001);
        chk("n_credit", {28'd0, credit}, 32'd1);

        // Acks on non-granted ports are ignored
        pulse_ack(4'b1110, "ig");
        chk("ig_grant",  {28'd0, grant},  32'b0001);
        chk("ig_credit", {28'd0, credit}, 32'd1);

        // Port 3 with credit 4, request dropped before ack
        weight  = {4'd4, 4'd2, 4'd1, 4'd1};
        request = 4'b1000;
        pulse_ack(4'b0001, "p3a");
        chk("p3_grant",  {28'd0, grant},  32'b1000);
        chk("p3_credit", {28'd0, credit}, 32'd4);
        request = 4'b0001;
        pulse_ack(4'b1000, "p3b");
        chk("p3_next",   {28'd0, grant},  32'b0001);
        request = 4'b1000;
        pulse_ack(4'b0001, "p3c");
        chk("p3_again",  {28'd0, grant},  32'b1000);
        request = '0;
        pulse_ack(4'b1000, "p3d");
        chk("p3_idle_valid",  {31'd0, grant_valid}, 32'd0);
        chk("p3_idle_credit", {28'd0, credit},      32'd0);

        // Asynchronous reset mid-frame
        request = 4'b0100;
        step("ar0");
        chk("ar_grant", {28'd0, grant}, 32'b0100);
        model_edge();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_drop_grant",  {28'd0, grant},         32'd0);
        chk("ar_drop_valid",  {31'd0, grant_valid},   32'd0);
        chk("ar_drop_credit", {28'd0, credit},        32'd0);
        chk("ar_drop_enc",    {30'd0, grant_encoded}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step("ar1");
        chk("ar_regrant", {28'd0, grant},  32'b0100);
        chk("ar_credit",  {28'd0, credit}, 32'd2);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            if (c % 40 == 0) begin
                for (int i = 0; i < P; i++) begin
                    weight[i*WW +: WW] = WW'($urandom_range(0, 3));
                end
            end
            if ($urandom_range(0, 3) == 0) begin
                request = P'($urandom_range(0, 15));
            end
            acknowledge = P'($urandom_range(0, 15)) & P'($urandom_range(0, 15));
            if (m_owner >= 0 && $urandom_range(0, 2) == 0) begin
                acknowledge[m_owner] = 1'b1;
            end
            step("rnd");
        end
        acknowledge = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
